// File: rtl/rf_alu_sequencer.sv
// rtl/rf_alu_sequencer.sv - register-file ALU sequencer; optional RF_ZERO_REG_EN makes r0 read as zero and ignore writes
module rf_alu_sequencer #(
  parameter int DW = 16,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  input  logic [DW-1:0] instr_imm,
  output logic [AW-1:0] rf_read_adr1,
  output logic [AW-1:0] rf_read_adr2,
  output logic          rf_read1_valid,
  output logic          rf_read2_valid,
  input  logic [DW-1:0] rf_read1,
  input  logic [DW-1:0] rf_read2,
  output logic [AW-1:0] rf_write_adr,
  output logic [DW-1:0] rf_data,
  output logic          rf_write_valid,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          carry
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  state_t        state;
  state_t        state_next;
  logic          ready_q;
  logic          transfer;

  logic [2:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rs1_q;
  logic [AW-1:0] rs2_q;
  logic [DW-1:0] imm_q;

  logic [DW-1:0] opa_q;
  logic [DW-1:0] opb_q;
  logic [DW-1:0] opa_in;
  logic [DW-1:0] opb_in;
  logic [DW-1:0] result_q;
  logic          carry_q;

  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic [DW-1:0] alu_res;
  logic          alu_carry;
  logic          write_en;

  assign transfer = instr_valid & ready_q;

`ifdef RF_ZERO_REG_EN
  assign opa_in   = (rs1_q == '0) ? '0 : rf_read1;
  assign opb_in   = (rs2_q == '0) ? '0 : rf_read2;
  assign write_en = (rd_q != '0);
`else
  assign opa_in   = rf_read1;
  assign opb_in   = rf_read2;
  assign write_en = 1'b1;
`endif

  // State register; instr_ready is a flop that anticipates the return to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ready_q <= 1'b1;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == S_IDLE);
    end
  end

  // Next-state decode and per-state strobes
  always_comb begin
    state_next     = state;
    rf_read1_valid = 1'b0;
    rf_read2_valid = 1'b0;
    rf_write_valid = 1'b0;
    done           = 1'b0;
    case (state)
      S_IDLE: begin
        if (transfer) begin
          state_next = (instr_op == OP_LDI) ? S_EXEC : S_READ;
        end
      end
      S_READ: begin
        rf_read1_valid = 1'b1;
        rf_read2_valid = 1'b1;
        state_next     = S_WAIT;
      end
      S_WAIT: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        state_next = S_WRITE;
      end
      S_WRITE: begin
        rf_write_valid = write_en;
        done           = 1'b1;
        state_next     = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Capture the instruction fields on the accepting edge only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
    end else if (state == S_IDLE && transfer) begin
      op_q  <= instr_op;
      rd_q  <= instr_rd;
      rs1_q <= instr_rs1;
      rs2_q <= instr_rs2;
      imm_q <= instr_imm;
    end
  end

  // Register file data is registered, so operands are taken one cycle after the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (state == S_WAIT) begin
      opa_q <= opa_in;
      opb_q <= opb_in;
    end
  end

  // ALU; carry holds its old value for everything except ADD and SUB
  always_comb begin
    sum       = {1'b0, opa_q} + {1'b0, opb_q};
    diff      = {1'b0, opa_q} - {1'b0, opb_q};
    alu_res   = '0;
    alu_carry = carry_q;
    case (op_q)
      OP_ADD: begin
        alu_res   = sum[DW-1:0];
        alu_carry = sum[DW];
      end
      OP_SUB: begin
        alu_res   = diff[DW-1:0];
        alu_carry = diff[DW];
      end
      OP_AND: alu_res = opa_q & opb_q;
      OP_OR:  alu_res = opa_q | opb_q;
      OP_XOR: alu_res = opa_q ^ opb_q;
      OP_SHL: alu_res = opa_q << opb_q[3:0];
      OP_SHR: alu_res = opa_q >> opb_q[3:0];
      OP_LDI: alu_res = imm_q;
    endcase
  end

  // Result and carry are registered in EXEC and presented during WRITE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
    end else if (state == S_EXEC) begin
      result_q <= alu_res;
      carry_q  <= alu_carry;
    end
  end

  assign instr_ready  = ready_q;
  assign busy         = (state != S_IDLE);
  assign rf_read_adr1 = rs1_q;
  assign rf_read_adr2 = rs2_q;
  assign rf_write_adr = rd_q;
  assign rf_data      = result_q;
  assign result       = result_q;
  assign carry        = carry_q;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// tb/tb_rf_alu_sequencer.sv - self-checking bench for rf_alu_sequencer
module tb_rf_alu_sequencer;

  localparam int DW = 16;
  localparam int AW = 5;
`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [DW-1:0] imm;
    logic [DW-1:0] exp_data;
    logic          exp_c;
    logic          exp_wv;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [2:0]    instr_op = '0;
  logic [AW-1:0] instr_rd = '0;
  logic [AW-1:0] instr_rs1 = '0;
  logic [AW-1:0] instr_rs2 = '0;
  logic [DW-1:0] instr_imm = '0;
  logic [AW-1:0] rf_read_adr1;
  logic [AW-1:0] rf_read_adr2;
  logic          rf_read1_valid;
  logic          rf_read2_valid;
  logic [DW-1:0] rf_read1 = '0;
  logic [DW-1:0] rf_read2 = '0;
  logic [AW-1:0] rf_write_adr;
  logic [DW-1:0] rf_data;
  logic          rf_write_valid;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          carry;

  rf_alu_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_op       (instr_op),
    .instr_rd       (instr_rd),
    .instr_rs1      (instr_rs1),
    .instr_rs2      (instr_rs2),
    .instr_imm      (instr_imm),
    .rf_read_adr1   (rf_read_adr1),
    .rf_read_adr2   (rf_read_adr2),
    .rf_read1_valid (rf_read1_valid),
    .rf_read2_valid (rf_read2_valid),
    .rf_read1       (rf_read1),
    .rf_read2       (rf_read2),
    .rf_write_adr   (rf_write_adr),
    .rf_data        (rf_data),
    .rf_write_valid (rf_write_valid),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .carry          (carry)
  );

  always #5 clk = ~clk;

  // Register file the sequencer talks to: registered reads, plain writes
  logic [DW-1:0] rf_mem [32] = '{default: '0};
  always @(posedge clk) begin
    if (rf_read1_valid) rf_read1 <= rf_mem[rf_read_adr1];
    if (rf_read2_valid) rf_read2 <= rf_mem[rf_read_adr2];
    if (rf_write_valid) rf_mem[rf_write_adr] <= rf_data;
  end

  // Log of every write strobe seen
  int            wr_count = 0;
  logic [AW-1:0] wr_adr_log [$];
  logic [DW-1:0] wr_dat_log [$];
  always @(negedge clk) begin
    if (rf_write_valid) begin
      wr_count++;
      wr_adr_log.push_back(rf_write_adr);
      wr_dat_log.push_back(rf_data);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Architectural reference model: register contents and carry flag
  logic [DW-1:0] model_mem [32] = '{default: '0};
  logic          model_carry = 1'b0;

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] adr);
    if (ZERO_REG && adr == '0) return '0;
    return model_mem[adr];
  endfunction

  task automatic model_exec(input vec_t v, output logic [DW-1:0] data, output logic c, output logic wv);
    int a;
    int b;
    int r;
    a = 32'(model_rd(v.rs1));
    b = 32'(model_rd(v.rs2));
    c = model_carry;
    r = 0;
    case (v.op)
      3'd0: begin r = a + b; c = (r >= (1 << DW)); end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << (b % 16);
      3'd6: r = a >> (b % 16);
      default: r = 32'(v.imm);
    endcase
    data = DW'(r);
    model_carry = c;
    wv = !(ZERO_REG && v.rd == '0);
    if (wv) model_mem[v.rd] = data;
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                              input logic [AW-1:0] rs2, input logic [DW-1:0] imm, input logic [DW-1:0] ed,
                              input logic ec, input logic ew);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.exp_data = ed; v.exp_c = ec; v.exp_wv = ew;
    return v;
  endfunction

  logic [DW-1:0] obs_data;
  logic          obs_carry;
  int            obs_wv;
  int            obs_lat;
  int            obs_strobes;
  logic          obs_adr_ok;
  logic [DW-1:0] obs_result;
  logic          obs_ready;

  // Issue one instruction from a negedge and follow it to the cycle after write-back
  task automatic run_instr(input vec_t v);
    int guard;
    instr_op = v.op; instr_rd = v.rd; instr_rs1 = v.rs1; instr_rs2 = v.rs2; instr_imm = v.imm;
    instr_valid = 1'b1;
    guard = 0;
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    obs_lat = 0; obs_wv = 0; obs_strobes = 0; obs_adr_ok = 1'b1;
    obs_data = '0; obs_carry = 1'b0;
    do begin
      @(negedge clk);
      obs_lat++;
      if (rf_read1_valid || rf_read2_valid) begin
        obs_strobes++;
        if (!(rf_read1_valid && rf_read2_valid) || rf_read_adr1 !== v.rs1 || rf_read_adr2 !== v.rs2)
          obs_adr_ok = 1'b0;
      end
      if (rf_write_valid) obs_wv++;
      if (done) begin
        obs_data  = rf_data;
        obs_carry = carry;
        if (rf_write_adr !== v.rd) obs_adr_ok = 1'b0;
      end
    end while (!done && obs_lat < 12);
    @(negedge clk);
    obs_result = result;
    obs_ready  = instr_ready;
  endtask

  task automatic check_run(input string tag, input vec_t v, input logic [DW-1:0] ed, input logic ec, input logic ew);
    bit is_ldi;
    is_ldi = (v.op == 3'd7);
    chk({tag, " rf_data"}, 32'(obs_data), 32'(ed));
    chk({tag, " carry"}, 32'(obs_carry), 32'(ec));
    chk({tag, " write_pulses"}, obs_wv, 32'(ew));
    chk({tag, " latency"}, obs_lat, is_ldi ? 32'd2 : 32'd4);
    chk({tag, " read_strobes"}, obs_strobes, is_ldi ? 32'd0 : 32'd1);
    chk({tag, " addresses"}, 32'(obs_adr_ok), 32'd1);
    chk({tag, " result_held"}, 32'(obs_result), 32'(ed));
    chk({tag, " ready_after"}, 32'(obs_ready), 32'd1);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, " instr_ready"}, 32'(instr_ready), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " read_strobes"}, 32'({rf_read1_valid, rf_read2_valid}), 32'd0);
    chk({tag, " rf_write_valid"}, 32'(rf_write_valid), 32'd0);
    chk({tag, " read_adrs"}, 32'({rf_read_adr1, rf_read_adr2}), 32'd0);
    chk({tag, " rf_write_adr"}, 32'(rf_write_adr), 32'd0);
    chk({tag, " rf_data"}, 32'(rf_data), 32'd0);
    chk({tag, " result"}, 32'(result), 32'd0);
    chk({tag, " carry"}, 32'(carry), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t          vecs [$];
    vec_t          v;
    vec_t          hs [3];
    logic [DW-1:0] hs_exp [3];
    int            hs_cyc [3];
    logic [DW-1:0] ed;
    logic          ec;
    logic          ew;
    int            wcnt;
    int            idx;
    int            guard;
    int            base;
    bit            take;

    vecs.push_back(mk(3'd7, 5'd3,  5'd0, 5'd0, 16'h1234, 16'h1234, 1'b0, 1'b1));
    vecs.push_back(mk(3'd7, 5'd1,  5'd0, 5'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1));
    vecs.push_back(mk(3'd7, 5'd2,  5'd0, 5'd0, 16'h0002, 16'h0002, 1'b0, 1'b1));
    vecs.push_back(mk(3'd0, 5'd4,  5'd1, 5'd2, 16'h0000, 16'h0001, 1'b1, 1'b1));
    vecs.push_back(mk(3'd1, 5'd1,  5'd2, 5'd1, 16'h0000, 16'h0003, 1'b1, 1'b1));
    vecs.push_back(mk(3'd7, 5'd2,  5'd0, 5'd0, 16'h0003, 16'h0003, 1'b1, 1'b1));
    vecs.push_back(mk(3'd7, 5'd6,  5'd0, 5'd0, 16'h0013, 16'h0013, 1'b1, 1'b1));
    vecs.push_back(mk(3'd5, 5'd5,  5'd2, 5'd6, 16'h0000, 16'h0018, 1'b1, 1'b1));
    vecs.push_back(mk(3'd7, 5'd1,  5'd0, 5'd0, 16'h8000, 16'h8000, 1'b1, 1'b1));
    vecs.push_back(mk(3'd6, 5'd5,  5'd1, 5'd6, 16'h0000, 16'h1000, 1'b1, 1'b1));
    vecs.push_back(mk(3'd1, 5'd10, 5'd3, 5'd2, 16'h0000, 16'h1231, 1'b0, 1'b1));
    vecs.push_back(mk(3'd0, 5'd9,  5'd3, 5'd3, 16'h0000, 16'h2468, 1'b0, 1'b1));
    vecs.push_back(mk(3'd2, 5'd11, 5'd3, 5'd6, 16'h0000, 16'h0010, 1'b0, 1'b1));
    vecs.push_back(mk(3'd3, 5'd12, 5'd3, 5'd6, 16'h0000, 16'h1237, 1'b0, 1'b1));
    vecs.push_back(mk(3'd4, 5'd13, 5'd3, 5'd6, 16'h0000, 16'h1227, 1'b0, 1'b1));
    vecs.push_back(mk(3'd7, 5'd7,  5'd0, 5'd0, 16'h0010, 16'h0010, 1'b0, 1'b1));
    vecs.push_back(mk(3'd5, 5'd8,  5'd3, 5'd7, 16'h0000, 16'h1234, 1'b0, 1'b1));
    vecs.push_back(mk(3'd6, 5'd8,  5'd1, 5'd3, 16'h0000, 16'h0800, 1'b0, 1'b1));
    vecs.push_back(mk(3'd0, 5'd14, 5'd1, 5'd1, 16'h0000, 16'h0000, 1'b1, 1'b1));
    vecs.push_back(mk(3'd7, 5'd0,  5'd0, 5'd0, 16'h5555, 16'h5555, 1'b1, !ZERO_REG));
    vecs.push_back(mk(3'd0, 5'd7,  5'd0, 5'd2, 16'h0000, ZERO_REG ? 16'h0003 : 16'h5558, 1'b0, 1'b1));
    vecs.push_back(mk(3'd0, 5'd2,  5'd2, 5'd2, 16'h0000, 16'h0006, 1'b0, 1'b1));

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      model_exec(v, ed, ec, ew);
      run_instr(v);
      check_run($sformatf("vec%0d", i), v, v.exp_data, v.exp_c, v.exp_wv);
    end

    v = mk(3'd0, 5'd21, 5'd1, 5'd1, 16'h0000, 16'h0000, 1'b1, 1'b1);
    model_exec(v, ed, ec, ew);
    run_instr(v);
    check_run("add_before_reset", v, ed, ec, ew);

    instr_op = 3'd1; instr_rd = 5'd20; instr_rs1 = 5'd3; instr_rs2 = 5'd2; instr_imm = '0;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midop busy_in_exec", 32'(busy), 32'd1);
    wcnt = wr_count;
    #1 rst_n = 1'b0;
    #1 check_idle_zero("midop_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midop no_write", wr_count, wcnt);
    rst_n = 1'b1;
    model_carry = 1'b0;

    hs[0] = mk(3'd7, 5'd15, 5'd0,  5'd0,  16'h00AA, 16'h0000, 1'b0, 1'b1);
    hs[1] = mk(3'd0, 5'd16, 5'd15, 5'd15, 16'h0000, 16'h0000, 1'b0, 1'b1);
    hs[2] = mk(3'd4, 5'd17, 5'd16, 5'd15, 16'h0000, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      model_exec(hs[i], ed, ec, ew);
      hs_exp[i] = ed;
      hs_cyc[i] = 0;
    end
    base = wr_adr_log.size();
    idx = 0;
    guard = 0;
    while (idx < 3 && guard < 60) begin
      instr_valid = 1'b1;
      if (instr_ready) begin
        instr_op = hs[idx].op; instr_rd = hs[idx].rd; instr_rs1 = hs[idx].rs1;
        instr_rs2 = hs[idx].rs2; instr_imm = hs[idx].imm;
      end else begin
        instr_op = 3'($urandom); instr_rd = AW'($urandom); instr_rs1 = AW'($urandom);
        instr_rs2 = AW'($urandom); instr_imm = DW'($urandom);
      end
      take = instr_ready;
      @(posedge clk);
      if (take) begin
        hs_cyc[idx] = guard;
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    instr_valid = 1'b0;
    chk("hs accepted", idx, 32'd3);
    chk("hs spacing_ldi", hs_cyc[1] - hs_cyc[0], 32'd3);
    chk("hs spacing_alu", hs_cyc[2] - hs_cyc[1], 32'd5);
    guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("hs drained", 32'(busy), 32'd0);
    chk("hs write_count", wr_adr_log.size() - base, 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < wr_adr_log.size()) begin
        chk($sformatf("hs%0d adr", i), 32'(wr_adr_log[base + i]), 32'(hs[i].rd));
        chk($sformatf("hs%0d data", i), 32'(wr_dat_log[base + i]), 32'(hs_exp[i]));
      end
    end

    for (int i = 0; i < 40; i++) begin
      v = mk(3'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), DW'($urandom), '0, 1'b0, 1'b0);
      model_exec(v, ed, ec, ew);
      run_instr(v);
      check_run($sformatf("rand%0d op%0d", i, v.op), v, ed, ec, ew);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
